microwave_timer: RTL and testbench
==================================

# microwave_timer

Countdown timer stage fed directly by the keypad encoder. It shifts each digit the encoder presents on `D` (strobed by `loadn`) into a three-digit M:SS register. On start, it counts that value down once per second from an internal prescaler. It flags `done` at 0:00. Its digit outputs drive the display decoders, and its `counting`/`done` flags drive the magnetron and buzzer control.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per one-second tick; legal range ≥ 2 (bench uses 4).
- `clk`  in  1  system clock; all state changes on rising edge.
- `clearn`  in  1  asynchronous active-low reset.
- `D`  in  4  BCD digit from the encoder; valid only while `loadn` = 0.
- `loadn`  in  1  active-low, one-cycle digit strobe from the encoder.
- `startn`  in  1  active-low start/resume request, sampled each cycle.
- `stopn`  in  1  active-low pause/clear request, sampled each cycle.
- `min`  out  4  minutes digit, 0–9.
- `sec_tens`  out  4  seconds-tens digit, 0–9 after entry, 0–5 after any borrow.
- `sec_units`  out  4  seconds-units digit, 0–9.
- `counting`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.

## Operation
- Reset is asynchronous on `clearn` low.
  - All digits go to 0, the prescaler goes to 0, and the state goes to IDLE.
  - `counting` = 0 and `done` = 0.
- FSM states are IDLE, RUN, PAUSE and DONE.
- IDLE:
  - `loadn` = 0 with `D` ≤ 9 shifts left: `min` ← `sec_tens`, `sec_tens` ← `sec_units`, `sec_units` ← `D`. The old `min` is discarded.
  - `D` ≥ 10 with `loadn` = 0 is ignored and the digits are unchanged.
  - `stopn` = 0 clears all digits to 0.
  - `startn` = 0 with a nonzero count → RUN and the prescaler goes to 0. `startn` = 0 with count 0:00 is ignored.
- RUN:
  - The prescaler increments each cycle. At `TICK_DIV`-1 it wraps to 0 and the count decrements.
  - `loadn` is ignored.
  - `stopn` = 0 → PAUSE. The prescaler holds and the digits hold.
- Decrement rule:
  - If `sec_units` > 0: `sec_units`-1.
  - Else `sec_units` ← 9. Then if `sec_tens` > 0: `sec_tens`-1. Else `sec_tens` ← 5 and `min`-1.
  - Entered values such as 0:99 count down as plain BCD; 0:90 → 0:89.
- If a decrement's result is 0:00, the state goes to DONE on that same edge.
- PAUSE:
  - `startn` = 0 → RUN. The prescaler resumes from its held value.
  - `stopn` = 0 clears all digits and the prescaler → IDLE.
  - `loadn` is ignored.
- DONE:
  - `stopn` = 0 → IDLE, digits remain 0.
  - `loadn` = 0 with a valid `D` → IDLE and that digit is shifted in on the same edge.
  - `startn` is ignored.
- Simultaneous requests: `stopn` beats `startn`; `stopn` beats `loadn` (clear wins, the digit is dropped); `stopn` in RUN beats a same-cycle tick (no decrement).

## Timing
- All outputs are registered. The digit shift is visible the cycle after the `loadn` edge.
- `counting` rises on the edge that samples `startn` = 0 in IDLE/PAUSE. It falls on the edge entering PAUSE or DONE.
- The first decrement occurs `TICK_DIV` cycles after RUN entry from IDLE.
- After resume, the first decrement occurs `TICK_DIV` minus the held prescaler cycles.
- `done` rises on the same edge that loads 0:00. It stays high until leaving DONE.
- Asserting `clearn` mid-RUN returns everything to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then `loadn` pulses with `D` = 1, 3, 0 → digits 0:01, 0:13, 1:30; `counting` = 0, `done` = 0.
- 1:30 loaded, `TICK_DIV` = 4, `startn` pulse → `counting` = 1.
  - 1:29 appears 4 cycles after start.
  - Borrows: 1:00 → 0:59 and 0:10 → 0:09.
- 0:02 loaded and run → 0:01 then 0:00 with `done` = 1 and `counting` = 0 on the same edge.
  - `loadn` with `D` = 5 → IDLE, display 0:05, `done` = 0.
- RUN at 0:45 with prescaler mid-count, `stopn` pulse → PAUSE, digits hold for 20 cycles.
  - `startn` → remaining cycles elapse before 0:44.
  - A second `stopn` while paused → 0:00, IDLE.
- In IDLE: `loadn` with `D` = 12 → digits unchanged. `startn` at 0:00 → stays IDLE.
  - `startn` and `stopn` low together at 0:30 → clear to 0:00, no RUN.
- `clearn` pulsed low mid-RUN between clock edges → digits 0:00, `counting` = 0 and `done` = 0 immediately.

Source files
------------

// File: rtl/microwave_timer_if.sv
// ---------------------------------------------------------------------------
// microwave_timer_if
//   Signal bundle between the keypad encoder / control logic and the
//   microwave countdown timer.
//
//   Encoder side (master drives):
//     D[3:0]     BCD digit, valid while loadn = 0
//     loadn      active-low one-cycle digit strobe
//     startn     active-low start/resume request
//     stopn      active-low pause/clear request
//   Timer side (slave drives):
//     min, sec_tens, sec_units   M:SS display digits (BCD)
//     counting                   high while counting down
//     done                       high once 0:00 has been reached
// ---------------------------------------------------------------------------
interface microwave_timer_if;
    logic [3:0] D;
    logic       loadn;
    logic       startn;
    logic       stopn;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic       counting;
    logic       done;

    modport master (
        output D, loadn, startn, stopn,
        input  min, sec_tens, sec_units, counting, done
    );

    modport slave (
        input  D, loadn, startn, stopn,
        output min, sec_tens, sec_units, counting, done
    );
endinterface

// File: rtl/microwave_timer.sv
// ---------------------------------------------------------------------------
// microwave_timer
//   Three-digit M:SS countdown timer. Digits are shifted in from the keypad
//   encoder while idle, then counted down once per TICK_DIV clock cycles
//   after a start request. Flags done when the count reaches 0:00.
//
//   Parameters:
//     TICK_DIV   clock cycles per one-second tick (>= 2)
//   Ports:
//     clk        system clock, rising edge
//     clearn     asynchronous active-low reset
//     bus        microwave_timer_if.slave (digit entry, start/stop requests,
//                display digits, counting/done flags)
// ---------------------------------------------------------------------------
module microwave_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                   clk,
    input  logic                   clearn,
    microwave_timer_if.slave       bus
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    state_t          state_q, state_d;
    bcd_t            cnt_q, cnt_d;
    bcd_t            cnt_dec;
    logic [PW-1:0]   presc_q, presc_d;
    logic            counting_q, counting_d;
    logic            done_q, done_d;

    logic            digit_ok;
    logic            cnt_zero;
    bcd_t            cnt_shift;

    assign digit_ok  = !bus.loadn && (bus.D <= 4'd9);
    assign cnt_zero  = (cnt_q == '0);
    assign cnt_shift = '{min: cnt_q.tens, tens: cnt_q.units, units: bus.D};

    // One-second decrement with borrow; entered digits above 5 in the tens
    // position simply count down as plain BCD until the first borrow.
    always_comb begin
        cnt_dec = cnt_q;
        if (cnt_q.units != 4'd0) begin
            cnt_dec.units = cnt_q.units - 4'd1;
        end else begin
            cnt_dec.units = 4'd9;
            if (cnt_q.tens != 4'd0) begin
                cnt_dec.tens = cnt_q.tens - 4'd1;
            end else begin
                cnt_dec.tens = 4'd5;
                cnt_dec.min  = cnt_q.min - 4'd1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;

        unique case (state_q)
            IDLE: begin
                // Clear beats start and load; start beats a same-cycle digit.
                if (!bus.stopn) begin
                    cnt_d = '0;
                end else if (!bus.startn && !cnt_zero) begin
                    state_d = RUN;
                    presc_d = '0;
                end else if (digit_ok) begin
                    cnt_d = cnt_shift;
                end
            end
            RUN: begin
                // A stop request suppresses a tick falling on the same edge.
                if (!bus.stopn) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    cnt_d   = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = DONE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            PAUSE: begin
                if (!bus.stopn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                end else if (!bus.startn) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (!bus.stopn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (digit_ok) begin
                    state_d = IDLE;
                    cnt_d   = cnt_shift;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags are registered from the next state so they change on the
        // same edge as the state itself.
        counting_d = (state_d == RUN);
        done_d     = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            presc_q    <= '0;
            counting_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            counting_q <= counting_d;
            done_q     <= done_d;
        end
    end

    assign bus.min       = cnt_q.min;
    assign bus.sec_tens  = cnt_q.tens;
    assign bus.sec_units = cnt_q.units;
    assign bus.counting  = counting_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_microwave_timer.sv
// ---------------------------------------------------------------------------
// tb_microwave_timer
//   Directed bench for microwave_timer with TICK_DIV = 4. Inputs change 1 ns
//   after a rising edge; outputs are checked at the same point, i.e. they
//   reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_microwave_timer;

    logic clk;
    logic clearn;
    int   vectors;
    int   miscompares;

    microwave_timer_if bus ();

    microwave_timer #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .clearn (clearn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {4'h0, bus.min, bus.sec_tens, bus.sec_units};
    endfunction

    function automatic logic [15:0] flags();
        return {14'h0, bus.counting, bus.done};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_digit(input logic [3:0] d);
        bus.D     = d;
        bus.loadn = 1'b0;
        tick(1);
        bus.loadn = 1'b1;
        bus.D     = 4'h0;
    endtask

    task automatic pulse_start();
        bus.startn = 1'b0;
        tick(1);
        bus.startn = 1'b1;
    endtask

    task automatic pulse_stop();
        bus.stopn = 1'b0;
        tick(1);
        bus.stopn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clearn      = 1'b0;
        bus.D       = 4'h0;
        bus.loadn   = 1'b1;
        bus.startn  = 1'b1;
        bus.stopn   = 1'b1;

        // Reset state
        tick(2);
        check("reset_disp", disp(), 16'h000);
        check("reset_flags", flags(), 16'h0);
        clearn = 1'b1;
        tick(1);

        // Digit entry
        load_digit(4'd1);
        check("load_1", disp(), 16'h001);
        load_digit(4'd3);
        check("load_3", disp(), 16'h013);
        load_digit(4'd0);
        check("load_0", disp(), 16'h130);
        check("idle_flags", flags(), 16'h0);

        // Run from 1:30; first decrement 4 edges after the start edge
        pulse_start();
        check("start_flags", flags(), 16'h2);
        check("start_disp", disp(), 16'h130);
        tick(3);
        check("pre_tick", disp(), 16'h130);
        tick(1);
        check("first_dec", disp(), 16'h129);
        tick(29 * 4);
        check("to_1_00", disp(), 16'h100);
        tick(4);
        check("borrow_min", disp(), 16'h059);
        tick(49 * 4);
        check("to_0_10", disp(), 16'h010);
        tick(4);
        check("borrow_tens", disp(), 16'h009);
        tick(8 * 4);
        check("at_0_01", disp(), 16'h001);
        check("at_0_01_flags", flags(), 16'h2);
        tick(4);
        check("done_disp", disp(), 16'h000);
        check("done_flags", flags(), 16'h1);

        // DONE ignores start; a valid digit returns to IDLE
        pulse_start();
        check("done_start_ign", flags(), 16'h1);
        load_digit(4'd5);
        check("done_load_disp", disp(), 16'h005);
        check("done_load_flags", flags(), 16'h0);

        // Clear in IDLE
        pulse_stop();
        check("idle_clear", disp(), 16'h000);

        // Pause/resume at 0:45 with prescaler mid-count (held at 2)
        load_digit(4'd4);
        load_digit(4'd5);
        check("load_45", disp(), 16'h045);
        pulse_start();
        tick(2);
        pulse_stop();
        check("pause_flags", flags(), 16'h0);
        tick(20);
        check("pause_hold", disp(), 16'h045);
        pulse_start();
        check("resume_flags", flags(), 16'h2);
        tick(1);
        check("resume_pre", disp(), 16'h045);
        tick(1);
        check("resume_dec", disp(), 16'h044);
        pulse_stop();
        check("pause2_disp", disp(), 16'h044);
        pulse_stop();
        check("pause_clear", disp(), 16'h000);
        check("pause_clear_fl", flags(), 16'h0);

        // IDLE boundaries
        pulse_start();
        check("start_zero_ign", flags(), 16'h0);
        load_digit(4'd3);
        load_digit(4'd9);
        check("load_d9", disp(), 16'h039);
        load_digit(4'd10);
        check("load_d10_ign", disp(), 16'h039);
        load_digit(4'd12);
        check("load_d12_ign", disp(), 16'h039);
        pulse_stop();
        load_digit(4'd3);
        load_digit(4'd0);
        check("load_30", disp(), 16'h030);
        bus.startn = 1'b0;
        bus.stopn  = 1'b0;
        tick(1);
        bus.startn = 1'b1;
        bus.stopn  = 1'b1;
        check("stop_beats_start", disp(), 16'h000);
        check("stop_beats_start_fl", flags(), 16'h0);
        load_digit(4'd7);
        bus.stopn = 1'b0;
        bus.D     = 4'd4;
        bus.loadn = 1'b0;
        tick(1);
        bus.stopn = 1'b1;
        bus.loadn = 1'b1;
        check("stop_beats_load", disp(), 16'h000);

        // Stop on the tick edge: no decrement
        load_digit(4'd2);
        pulse_start();
        tick(3);
        pulse_stop();
        check("stop_beats_tick", disp(), 16'h002);
        pulse_start();
        tick(1);
        check("resume_at_last", disp(), 16'h001);

        // Asynchronous clear between edges while running
        check("pre_clear_flags", flags(), 16'h2);
        #2;
        clearn = 1'b0;
        #1;
        check("async_clr_disp", disp(), 16'h000);
        check("async_clr_flags", flags(), 16'h0);
        tick(1);
        clearn = 1'b1;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
